// File: rtl/varredura_display.sv
// Scan controller sharing one active-low 7-segment bus across NUM_DIGITOS common-anode digits.
// Optional `SUPRIME_ZEROS_EN: blank leading-zero digits (digit 0 always shown).
module varredura_display #(
  parameter int NUM_DIGITOS  = 4,
  parameter int DIV_REFRESH  = 50000,
  parameter int BLANK_CICLOS = 500
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilitar,
  input  logic [4*NUM_DIGITOS-1:0] valores,
  input  logic [NUM_DIGITOS-1:0]   pontos,
  output logic [6:0]               segmentos,
  output logic                     ponto,
  output logic [NUM_DIGITOS-1:0]   anodos,
  output logic                     fim_varredura
);

  localparam int MAXC = (DIV_REFRESH > BLANK_CICLOS) ? DIV_REFRESH : BLANK_CICLOS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam logic [CW-1:0] FIM_DIV   = CW'(DIV_REFRESH - 1);
  localparam logic [CW-1:0] FIM_BLANK = (BLANK_CICLOS > 0) ? CW'(BLANK_CICLOS - 1) : '0;
  localparam logic [IW-1:0] ULTIMO    = IW'(NUM_DIGITOS - 1);

  typedef enum logic [1:0] {CARREGA, APAGADO, EXIBE, DESLIGADO} estado_t;

  estado_t                  estado, prox;
  logic [CW-1:0]            contador;
  logic [IW-1:0]            indice;
  logic [4*NUM_DIGITOS-1:0] snap_valores;
  logic [NUM_DIGITOS-1:0]   snap_pontos;
  logic [NUM_DIGITOS-1:0]   apaga;
  logic                     fim_blank, fim_exibe, ultimo;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  assign fim_blank = (contador == FIM_BLANK);
  assign fim_exibe = (contador == FIM_DIV);
  assign ultimo    = (indice == ULTIMO);

  always_comb begin
    prox = estado;
    if (!habilitar) prox = DESLIGADO;
    else begin
      case (estado)
        CARREGA:   prox = (BLANK_CICLOS == 0) ? EXIBE : APAGADO;
        APAGADO:   if (fim_blank) prox = EXIBE;
        EXIBE:     if (fim_exibe) prox = ultimo ? CARREGA
                                        : ((BLANK_CICLOS == 0) ? EXIBE : APAGADO);
        default:   prox = CARREGA;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= CARREGA;
      contador      <= '0;
      indice        <= '0;
      snap_valores  <= '0;
      snap_pontos   <= '0;
      fim_varredura <= 1'b0;
    end else begin
      estado        <= prox;
      // Pulse only on a completed scan; a disable on the last cycle swallows it.
      fim_varredura <= habilitar && (estado == EXIBE) && fim_exibe && ultimo;
      if (estado == CARREGA) begin
        snap_valores <= valores;
        snap_pontos  <= pontos;
      end
      if (!habilitar || estado == CARREGA || estado == DESLIGADO) begin
        contador <= '0;
        indice   <= '0;
      end else if (estado == APAGADO) begin
        contador <= fim_blank ? '0 : contador + 1'b1;
      end else if (fim_exibe) begin
        contador <= '0;
        if (!ultimo) indice <= indice + 1'b1;
      end else begin
        contador <= contador + 1'b1;
      end
    end
  end

`ifdef SUPRIME_ZEROS_EN
  always_comb begin
    logic zeros;
    zeros = 1'b1;
    apaga = '0;
    for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
      zeros    = zeros && (snap_valores[4*i +: 4] == 4'h0);
      apaga[i] = zeros;
    end
  end
`else
  assign apaga = '0;
`endif

  // Outputs depend only on registered state, so an async reset darkens them at once.
  always_comb begin
    anodos    = '1;
    segmentos = 7'h7F;
    ponto     = 1'b1;
    if (estado == EXIBE) begin
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        if (indice == IW'(i)) begin
          anodos[i] = 1'b0;
          segmentos = apaga[i] ? 7'h7F : decode(snap_valores[4*i +: 4]);
          ponto     = ~snap_pontos[i];
        end
      end
    end
  end

endmodule
